// File: rtl/segm2hex_scan.sv
// segm2hex_scan: decodes a scanned active-low 7-segment display back into a 16-bit hex value
module segm2hex_scan #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  segm,
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic [3:0]  digit_err
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  state_t st, st_nx;
  logic [10:0] cur, samp;
  logic [7:0] cnt, cnt_nx;
  logic vsel, chg, cap, done, bad;
  logic [3:0] oh, seen, seen_nx, derr_s, nib;
  logic [1:0] idx;
  logic [3:0][3:0] slot;
  assign cur = {dig_sel, segm};
  assign vsel = $onehot(~dig_sel);
  assign chg = cur != samp;
  assign oh = ~samp[10:7];
  assign idx = {oh[3] | oh[2], oh[3] | oh[1]};
  assign err = |digit_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
      cnt <= '0;
      samp <= '1;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      samp <= cur;
    end
  end
  // A change of the sampled pair restarts the run whether settling or holding
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    if (st == S_IDLE || chg) begin
      st_nx = vsel ? S_SETTLE : S_IDLE;
      cnt_nx = vsel ? 8'd1 : 8'd0;
    end else if (st == S_SETTLE) begin
      st_nx = cap ? S_HOLD : S_SETTLE;
      cnt_nx = cap ? cnt : cnt + 8'd1;
    end
  end
  always_comb begin
    cap = st == S_SETTLE && cnt == 8'(SETTLE);
    nib = 4'h0;
    bad = 1'b0;
    case (samp[6:0])
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default: bad = 1'b1;
    endcase
    // seen clears as the completed scan publishes, so a same-edge capture starts the next scan
    seen_nx = (done ? 4'h0 : seen) | (cap ? oh : 4'h0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      derr_s <= '0;
      seen <= '0;
      done <= 1'b0;
      value <= '0;
      valid <= 1'b0;
      digit_err <= '0;
    end else begin
      seen <= seen_nx;
      done <= cap && &seen_nx;
      valid <= done;
      if (cap) begin
        slot[idx] <= nib;
        derr_s[idx] <= bad;
      end
      if (done) begin
        value <= slot;
        digit_err <= derr_s;
      end
    end
  end
endmodule

// File: tb/tb_segm2hex_scan.sv
// tb_segm2hex_scan: vector table plus scoreboard of expected scan results for segm2hex_scan
module tb_segm2hex_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] segm = '1;
  logic [3:0] dig_sel = '1;
  logic [15:0] value;
  logic valid, err;
  logic [3:0] digit_err;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [15:0] val; logic [3:0] derr;} exp_t;
  typedef struct {logic [3:0][6:0] pat; int hold; logic [15:0] val; logic [3:0] derr;} vec_t;
  exp_t q[$];
  exp_t got;
  logic [15:0] m_val = '0;
  logic [3:0] m_derr = '0;
  vec_t tbl[6];
  logic [6:0] pt [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  segm2hex_scan #(.SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .segm(segm), .dig_sel(dig_sel),
    .value(value), .valid(valid), .err(err), .digit_err(digit_err)
  );

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_value", 32'(value), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_digit_err", 32'(digit_err), 32'h0);
      m_val = '0;
      m_derr = '0;
    end else if (valid) begin
      if (q.size() == 0) check("unexpected_valid", 32'h1, 32'h0);
      else begin
        got = q.pop_front();
        m_val = got.val;
        m_derr = got.derr;
      end
      check("scan_value", 32'(value), 32'(m_val));
      check("scan_digit_err", 32'(digit_err), 32'(m_derr));
      check("scan_err", 32'(err), 32'(|m_derr));
    end else begin
      check("held_value", 32'(value), 32'(m_val));
      check("held_digit_err", 32'(digit_err), 32'(m_derr));
      check("held_err", 32'(err), 32'(|m_derr));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [3:0] sel, input logic [6:0] p, input int n);
    dig_sel = sel;
    segm = p;
    tick(n);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] d);
    exp_t e;
    e.val = v;
    e.derr = d;
    q.push_back(e);
  endtask

  task automatic finish_scan();
    put(4'hF, 7'h7F, 5);
    if (q.size() != 0) begin
      check("missing_valid", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  initial begin
    tbl[0] = '{{pt[4], pt[3], pt[2], pt[1]}, 6, 16'h4321, 4'b0000};
    tbl[1] = '{{pt[13], pt[12], 7'h7F, pt[10]}, 6, 16'hDC0A, 4'b0010};
    tbl[2] = '{{pt[15], pt[9], pt[5], pt[0]}, 5, 16'hF950, 4'b0000};
    tbl[3] = '{{pt[14], pt[8], pt[7], pt[6]}, 4, 16'hE876, 4'b0000};
    tbl[4] = '{{pt[13], pt[1], pt[0], pt[8]}, 4, 16'hD108, 4'b0000};
    tbl[5] = '{{7'b0000001, pt[11], pt[11], pt[11]}, 6, 16'h0BBB, 4'b1000};
    tick(3);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].val, tbl[i].derr);
      for (int d = 0; d < 4; d++) put(~(4'b0001 << d), tbl[i].pat[d], tbl[i].hold);
      finish_scan();
    end
    push(16'h4567, 4'b0000);
    put(4'b0111, pt[4], 6);
    put(4'b1011, pt[5], 6);
    put(4'b1101, pt[6], 6);
    put(4'b1110, pt[7], 6);
    finish_scan();
    push(16'hE987, 4'b0000);
    put(4'b1110, pt[5], 6);
    put(4'b1110, pt[7], 6);
    put(4'b1101, pt[8], 6);
    put(4'b1011, pt[9], 6);
    put(4'b0111, pt[14], 6);
    finish_scan();
    put(4'b1110, pt[1], 6);
    put(4'b1101, pt[2], 6);
    put(4'b0111, pt[3], 6);
    put(4'b1011, pt[4], 3);
    put(4'hF, 7'h7F, 8);
    finish_scan();
    check("short_hold_value", 32'(value), 32'h0000E987);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    put(4'b1100, pt[8], 20);
    put(4'hF, 7'h7F, 2);
    push(16'hCBA9, 4'b0000);
    put(4'b1110, pt[9], 6);
    put(4'b1101, pt[10], 6);
    put(4'b1011, pt[11], 6);
    put(4'b0111, pt[12], 6);
    finish_scan();
    put(4'b1110, pt[1], 6);
    put(4'b1101, pt[2], 6);
    put(4'b1011, pt[3], 6);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    push(16'h0F0F, 4'b0000);
    put(4'b0111, pt[0], 6);
    put(4'b1011, pt[15], 6);
    put(4'b1101, pt[0], 6);
    put(4'b1110, pt[15], 6);
    finish_scan();
    check("final_value", 32'(value), 32'h00000F0F);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
